// File: rtl/operand_loader.sv
// Loads two 8-bit operands from switches on debounced confirm presses and
// forwards accepted mode presses once both operands are valid.
module operand_loader #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sw,
  input  logic       btn_confirm,
  input  logic       btn_mode,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic       button_press,
  output logic       enable,
  output logic [1:0] load_state
);

  localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    READY  = 2'b10
  } state_e;

  // Bit 0 is the confirm button, bit 1 the mode button.
  logic [1:0] btn_raw;
  logic [1:0] evt;

  assign btn_raw = {btn_mode, btn_confirm};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic          sync1_q, sync2_q;
      logic          stable_q, stable_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          evt_q, evt_d;

      always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        evt_d    = 1'b0;
        if (sync2_q != stable_q) begin
          if (cnt_q == CNT_LAST) begin
            // Level held long enough: accept it; only a rising level is an event.
            stable_d = ~stable_q;
            evt_d    = ~stable_q;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          sync1_q  <= 1'b0;
          sync2_q  <= 1'b0;
          stable_q <= 1'b0;
          cnt_q    <= '0;
          evt_q    <= 1'b0;
        end else begin
          sync1_q  <= btn_raw[gi];
          sync2_q  <= sync1_q;
          stable_q <= stable_d;
          cnt_q    <= cnt_d;
          evt_q    <= evt_d;
        end
      end

      assign evt[gi] = evt_q;
    end
  endgenerate

  logic       confirm_evt, mode_evt;
  state_e     state_q, state_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic       press_q, press_d;
  logic       enable_q, enable_d;

  assign confirm_evt = evt[0];
  assign mode_evt    = evt[1];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    press_d = 1'b0;
    case (state_q)
      LOAD_A: begin
        if (confirm_evt) begin
          a_d     = sw;
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        if (confirm_evt) begin
          b_d     = sw;
          state_d = READY;
        end
      end
      READY: begin
        // Confirm wins over a coincident mode event, which is then dropped.
        if (confirm_evt) begin
          state_d = LOAD_A;
        end else if (mode_evt) begin
          press_d = 1'b1;
        end
      end
      default: state_d = LOAD_A;
    endcase
    enable_d = (state_d == READY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= LOAD_A;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      press_q  <= 1'b0;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      press_q  <= press_d;
      enable_q <= enable_d;
    end
  end

  assign a            = a_q;
  assign b            = b_q;
  assign button_press = press_q;
  assign enable       = enable_q;
  assign load_state   = state_q;

endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader with a short debounce window: operand table plus
// hand sequences for bounce, mode presses, coincident presses and reset.
module tb_operand_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sw = 8'h00;
  logic       btn_confirm = 1'b0;
  logic       btn_mode = 1'b0;
  logic [7:0] a, b;
  logic       button_press, enable;
  logic [1:0] load_state;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_q[$];

  operand_loader #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk),
    .reset(reset),
    .sw(sw),
    .btn_confirm(btn_confirm),
    .btn_mode(btn_mode),
    .a(a),
    .b(b),
    .button_press(button_press),
    .enable(enable),
    .load_state(load_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s = %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  // Scoreboard: each button_press pulse must match a queued expected cycle.
  always @(negedge clk) begin
    if (button_press) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL press_unexpected: got pulse at cycle %0d want none", cyc);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (e != cyc) begin
          bad++;
          $display("FAIL press_cycle: got %0d want %0d", cyc, e);
        end else begin
          $display("ok   press at cycle %0d", cyc);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  // Press confirm for 10 cycles and check the exact cycle the state moves.
  task automatic confirm_press(input logic [7:0] s, input logic [1:0] prev_st,
                               input logic [1:0] st, input logic [7:0] ea,
                               input logic [7:0] eb, input logic en);
    step(1);
    sw = s;
    btn_confirm = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("state_before", load_state, prev_st);
    @(posedge clk);
    @(negedge clk);
    check("state_after", load_state, st);
    check("a", a, ea);
    check("b", b, eb);
    check("enable", enable, en);
    step(3);
    btn_confirm = 1'b0;
    step(12);
  endtask

  typedef struct {
    logic [7:0] sw;
    logic [1:0] prev_st;
    logic [1:0] st;
    logic [7:0] ea;
    logic [7:0] eb;
    logic       en;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{8'hA5, 2'b00, 2'b01, 8'hA5, 8'h00, 1'b0};
    vecs[1] = '{8'h3C, 2'b01, 2'b10, 8'hA5, 8'h3C, 1'b1};
    vecs[2] = '{8'h77, 2'b10, 2'b00, 8'hA5, 8'h3C, 1'b0};
    vecs[3] = '{8'h11, 2'b00, 2'b01, 8'h11, 8'h3C, 1'b0};
    vecs[4] = '{8'h22, 2'b01, 2'b10, 8'h11, 8'h22, 1'b1};

    step(3);
    reset = 1'b0;
    @(negedge clk);
    check("rst_a", a, 8'h00);
    check("rst_b", b, 8'h00);
    check("rst_enable", enable, 1'b0);
    check("rst_press", button_press, 1'b0);
    check("rst_state", load_state, 2'b00);

    // Bouncing confirm never holds 4 cycles.
    sw = 8'h99;
    for (int i = 0; i < 10; i++) begin
      btn_confirm = ~btn_confirm;
      step(2);
    end
    btn_confirm = 1'b0;
    step(10);
    check("bounce_state", load_state, 2'b00);
    check("bounce_a", a, 8'h00);

    // Mode press outside READY is dropped.
    btn_mode = 1'b1;
    step(10);
    btn_mode = 1'b0;
    step(12);
    check("mode_loada_state", load_state, 2'b00);

    for (int i = 0; i < 5; i++) begin
      confirm_press(vecs[i].sw, vecs[i].prev_st, vecs[i].st, vecs[i].ea,
                    vecs[i].eb, vecs[i].en);
    end

    // Mode press in READY: one pulse, 2 sync + 4 count + 1 register later.
    btn_mode = 1'b1;
    exp_q.push_back(cyc + 7);
    step(10);
    btn_mode = 1'b0;
    step(14);
    check("mode_ready_state", load_state, 2'b10);
    check("mode_queue_drained", exp_q.size(), 0);

    // Coincident presses in READY: confirm wins, mode dropped.
    btn_mode = 1'b1;
    btn_confirm = 1'b1;
    step(10);
    btn_mode = 1'b0;
    btn_confirm = 1'b0;
    step(12);
    check("both_state", load_state, 2'b00);
    check("both_enable", enable, 1'b0);
    check("both_a", a, 8'h11);
    check("both_b", b, 8'h22);

    // Reset mid-debounce while in LOAD_B with a=FF.
    confirm_press(8'hFF, 2'b00, 2'b01, 8'hFF, 8'h22, 1'b0);
    btn_confirm = 1'b1;
    step(3);
    reset = 1'b1;
    btn_confirm = 1'b0;
    step(2);
    reset = 1'b0;
    step(20);
    check("rstmid_a", a, 8'h00);
    check("rstmid_b", b, 8'h00);
    check("rstmid_state", load_state, 2'b00);
    check("rstmid_enable", enable, 1'b0);

    // Button held across reset release is accepted as a fresh press.
    sw = 8'h5A;
    btn_confirm = 1'b1;
    step(3);
    do_reset();
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("held_state_before", load_state, 2'b00);
    @(posedge clk);
    @(negedge clk);
    check("held_state_after", load_state, 2'b01);
    check("held_a", a, 8'h5A);
    step(3);
    btn_confirm = 1'b0;
    step(12);

    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
